// File: rtl/ecc_ctrl.sv
// ecc_ctrl: APB register bank and launch/latency sequencer for the ECC datapath.
// Holds the datapath operands, launches an operation on a CTRL write, counts the
// pipeline latency, captures the result and pulses operation_done.
module ecc_ctrl #(
  parameter int unsigned AMBA_WORD          = 32,
  parameter int unsigned AMBA_ADDR_WIDTH    = 20,
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  parameter int unsigned ENC_LATENCY        = 1,
  parameter int unsigned DEC_LATENCY        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [AMBA_WORD-1:0]          PWDATA,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          dp_start,
  output logic [1:0]                    dp_op,
  output logic [MAX_CODEWORD_WIDTH-1:0] dp_data_in,
  output logic [AMBA_WORD-1:0]          dp_work_mod,
  output logic [MAX_CODEWORD_WIDTH-1:0] dp_noise,
  input  logic [MAX_CODEWORD_WIDTH-1:0] dp_data_out,
  input  logic [1:0]                    dp_num_of_errors,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    num_of_errors,
  output logic                          operation_done
);

  localparam int unsigned LatMax = ENC_LATENCY + DEC_LATENCY;
  localparam int unsigned CntW   = $clog2(LatMax + 1);

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrDataIn = 3'd1;
  localparam logic [2:0] AddrCwW    = 3'd2;
  localparam logic [2:0] AddrNoise  = 3'd3;
  localparam logic [2:0] AddrStatus = 3'd4;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  state_e                          state_q;
  logic [1:0]                      ctrl_q;
  logic [MAX_CODEWORD_WIDTH-1:0]   data_in_q;
  logic [1:0]                      cw_q;
  logic [MAX_CODEWORD_WIDTH-1:0]   noise_q;
  logic                            illegal_q;
  logic [CntW-1:0]                 cnt_q;
  logic [MAX_CODEWORD_WIDTH-1:0]   data_out_q;
  logic [1:0]                      nerr_q;
  logic                            start_q;
  logic                            done_q;

  logic [2:0]      addr;
  logic            wr_en;
  logic            rd_en;
  logic            busy;
  logic [CntW-1:0] lat_sel;

  assign addr  = PADDR[4:2];
  assign wr_en = PSEL & PENABLE & PWRITE;
  assign rd_en = PSEL & PENABLE & ~PWRITE;
  assign busy  = (state_q != StIdle);

  // Address bits outside [4:2] and the info width are not needed by this block.
  logic        unused_addr;
  logic [31:0] unused_info;
  assign unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};
  assign unused_info = MAX_INFO_WIDTH;

  // Pipeline latency for the pending operation.
  always_comb begin
    lat_sel = CntW'(LatMax);
    case (ctrl_q)
      2'd0:    lat_sel = CntW'(ENC_LATENCY);
      2'd1:    lat_sel = CntW'(DEC_LATENCY);
      default: lat_sel = CntW'(LatMax);
    endcase
  end

  // Register bank, sequencer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      data_in_q  <= '0;
      cw_q       <= '0;
      noise_q    <= '0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
      data_out_q <= '0;
      nerr_q     <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Writes are only honoured here, so operands are frozen while busy.
          if (wr_en) begin
            case (addr)
              AddrCtrl: begin
                ctrl_q <= PWDATA[1:0];
                if (PWDATA[1:0] == 2'd3 || cw_q == 2'd3) begin
                  illegal_q <= 1'b1;
                end else begin
                  illegal_q <= 1'b0;
                  start_q   <= 1'b1;
                  state_q   <= StLaunch;
                end
              end
              AddrDataIn: data_in_q <= PWDATA[MAX_CODEWORD_WIDTH-1:0];
              AddrCwW:    cw_q      <= PWDATA[1:0];
              AddrNoise:  noise_q   <= PWDATA[MAX_CODEWORD_WIDTH-1:0];
              default: ;
            endcase
          end
        end
        StLaunch: begin
          cnt_q   <= lat_sel;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == CntW'(1)) begin
            data_out_q <= dp_data_out;
            nerr_q     <= (ctrl_q == 2'd0) ? 2'd0 : dp_num_of_errors;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  // Combinational read mux, zero outside a read access phase.
  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (addr)
        AddrCtrl:   PRDATA = AMBA_WORD'(ctrl_q);
        AddrDataIn: PRDATA = AMBA_WORD'(data_in_q);
        AddrCwW:    PRDATA = AMBA_WORD'(cw_q);
        AddrNoise:  PRDATA = AMBA_WORD'(noise_q);
        AddrStatus: PRDATA = AMBA_WORD'({nerr_q, 2'b00, illegal_q, busy});
        default:    PRDATA = '0;
      endcase
    end
  end

  assign dp_start       = start_q;
  assign dp_op          = ctrl_q;
  assign dp_data_in     = data_in_q;
  assign dp_work_mod    = AMBA_WORD'(cw_q);
  assign dp_noise       = noise_q;
  assign data_out       = data_out_q;
  assign num_of_errors  = nerr_q;
  assign operation_done = done_q;

endmodule

// File: tb/tb_ecc_ctrl.sv
// Bench for ecc_ctrl: stub datapath with op-dependent delay, scoreboard queue of
// expected completions, and a monitor that checks each operation_done pulse.
module tb_ecc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        dp_start;
  logic [1:0]  dp_op;
  logic [31:0] dp_data_in, dp_work_mod, dp_noise, dp_data_out, data_out;
  logic [1:0]  dp_num_of_errors, num_of_errors;
  logic        operation_done;

  always #5 clk = ~clk;

  ecc_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .PADDR            (PADDR),
    .PSEL             (PSEL),
    .PENABLE          (PENABLE),
    .PWRITE           (PWRITE),
    .PWDATA           (PWDATA),
    .PRDATA           (PRDATA),
    .dp_start         (dp_start),
    .dp_op            (dp_op),
    .dp_data_in       (dp_data_in),
    .dp_work_mod      (dp_work_mod),
    .dp_noise         (dp_noise),
    .dp_data_out      (dp_data_out),
    .dp_num_of_errors (dp_num_of_errors),
    .data_out         (data_out),
    .num_of_errors    (num_of_errors),
    .operation_done   (operation_done)
  );

  // Stub datapath: result valid 1/3/4 cycles after dp_start is sampled, 0 otherwise.
  logic [31:0] st_d[4];
  logic [1:0]  st_e[4];
  logic [31:0] stub_res;
  logic [1:0]  stub_err;

  always_comb begin
    stub_res = 32'h0;
    stub_err = 2'd0;
    case (dp_op)
      2'd0: begin stub_res = dp_data_in ^ 32'hA5A5A5A5; stub_err = 2'd3; end
      2'd1: begin stub_res = dp_data_in ^ dp_noise; stub_err = 2'd1; end
      default: begin stub_res = dp_data_in ^ dp_noise ^ 32'h0F0F0F0F; stub_err = 2'd2; end
    endcase
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin st_d[i] <= '0; st_e[i] <= '0; end
    end else begin
      st_d[0] <= dp_start ? stub_res : 32'h0;
      st_e[0] <= dp_start ? stub_err : 2'd0;
      for (int i = 1; i < 4; i++) begin st_d[i] <= st_d[i-1]; st_e[i] <= st_e[i-1]; end
    end
  end

  always_comb begin
    case (dp_op)
      2'd0:    begin dp_data_out = st_d[0]; dp_num_of_errors = st_e[0]; end
      2'd1:    begin dp_data_out = st_d[2]; dp_num_of_errors = st_e[2]; end
      default: begin dp_data_out = st_d[3]; dp_num_of_errors = st_e[3]; end
    endcase
  end

  typedef struct {
    logic [31:0] d;
    logic [1:0]  e;
    int          c;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   start_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (dp_start === 1'b1) start_cnt++;
    if (operation_done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_data", data_out, mon_e.d);
        chk("done_errs", {30'h0, num_of_errors}, {30'h0, mon_e.e});
        chk("done_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic apb_write(input logic [2:0] idx, input logic [31:0] val);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 20'(idx) << 2; PWDATA = val;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [31:0] val);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 20'(idx) << 2;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 val = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] v;
    apb_read(idx, v);
    chk(name, v, exp);
  endtask

  // Issue a CTRL write and queue the expected completion (cyc is now E0).
  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [1:0] e);
    int lat;
    lat = (op == 2'd0) ? 1 : (op == 2'd1) ? 3 : 4;
    apb_write(3'd0, {30'h0, op});
    sb_q.push_back('{d: d, e: e, c: cyc + 1 + lat});
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  int s0, d0;

  initial begin
    rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_nerr", {30'h0, num_of_errors}, 32'h0);
    chk("rst_ctl", {28'h0, operation_done, dp_start, dp_op}, 32'h0);
    chk("rst_dp_regs", dp_data_in | dp_work_mod | dp_noise, 32'h0);
    chk("rst_prdata_idle", PRDATA, 32'h0);
    for (int i = 0; i < 8; i++) read_chk("rst_read", 3'(i), 32'h0);

    // Encode, default width.
    apb_write(3'd2, 32'h0);
    apb_write(3'd1, 32'h5);
    s0 = start_cnt;
    run_op(2'd0, 32'hA5A5A5A0, 2'd0);
    wait_done();
    chk("enc_start_cnt", start_cnt, s0 + 1);
    read_chk("enc_status", 3'd4, 32'h0);

    // Full channel.
    apb_write(3'd2, 32'h2);
    apb_write(3'd3, 32'h3);
    run_op(2'd2, 32'h0F0F0F09, 2'd2);
    read_chk("full_status_busy", 3'd4, 32'h1);
    wait_done();
    read_chk("full_status", 3'd4, 32'h20);
    read_chk("rd_data_in", 3'd1, 32'h5);
    read_chk("rd_cw", 3'd2, 32'h2);
    read_chk("rd_noise", 3'd3, 32'h3);
    read_chk("rd_ctrl", 3'd0, 32'h2);

    // Busy protection: both writes land while the full-channel op is in WAIT.
    apb_write(3'd1, 32'h1234);
    s0 = start_cnt;
    d0 = done_cnt;
    run_op(2'd2, 32'h0F0F1D38, 2'd2);
    apb_write(3'd1, 32'hFFFF);
    apb_write(3'd0, 32'h1);
    wait_done();
    repeat (6) @(negedge clk);
    chk("busy_data_in", dp_data_in, 32'h1234);
    chk("busy_op", {30'h0, dp_op}, 32'h2);
    chk("busy_done_cnt", done_cnt, d0 + 1);
    chk("busy_start_cnt", start_cnt, s0 + 1);

    // Illegal op, then a legal decode clears the sticky bit.
    s0 = start_cnt;
    apb_write(3'd0, 32'h3);
    repeat (6) @(negedge clk);
    chk("illegal_no_start", start_cnt, s0);
    read_chk("illegal_status", 3'd4, 32'h22);
    run_op(2'd1, 32'h1237, 2'd1);
    wait_done();
    read_chk("dec_status", 3'd4, 32'h10);

    // Illegal width, then recover with a legal encode.
    apb_write(3'd2, 32'h7);
    read_chk("rd_cw3", 3'd2, 32'h3);
    s0 = start_cnt;
    apb_write(3'd0, 32'h0);
    repeat (4) @(negedge clk);
    chk("illegal_cw_no_start", start_cnt, s0);
    read_chk("illegal_cw_status", 3'd4, 32'h12);
    apb_write(3'd2, 32'h0);
    run_op(2'd0, 32'hA5A5B791, 2'd0);
    wait_done();
    read_chk("recover_status", 3'd4, 32'h0);

    // Reset during WAIT of a decode aborts it.
    apb_write(3'd1, 32'h00C0FFEE);
    s0 = start_cnt;
    d0 = done_cnt;
    apb_write(3'd0, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_data_out", data_out, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_one_start", start_cnt, s0 + 1);
    chk("midrst_data_out_hold", data_out, 32'h0);
    chk("midrst_data_in", dp_data_in, 32'h0);
    read_chk("midrst_status", 3'd4, 32'h0);

    apb_write(3'd1, 32'h11);
    run_op(2'd0, 32'hA5A5A5B4, 2'd0);
    wait_done();
    chk("post_rst_done_cnt", done_cnt, d0 + 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_ctrl.md
# ecc_ctrl

APB-slave register bank and operation sequencer for the ECC datapath (encoder stage 1 and the downstream decoder stages). It holds DATA_IN, CODEWORD_WIDTH (work_mod) and NOISE, and launches an encode, decode or full-channel operation when the CTRL register is written. It then counts the datapath pipeline latency, captures the result and number of errors, and signals completion. It sits between the APB bus and the ENC/DEC pipeline and is the only block that drives the datapath operand inputs.

## Interface
- AMBA_WORD, 32, APB data width and register width
- AMBA_ADDR_WIDTH, 20, APB address width; decode uses PADDR[4:2] only
- MAX_CODEWORD_WIDTH, 32, datapath codeword width
- MAX_INFO_WIDTH, 26, datapath info width
- ENC_LATENCY, 1, cycles from dp_start sampled to valid encoder result
- DEC_LATENCY, 3, cycles from dp_start sampled to valid decoder result; full channel uses ENC_LATENCY+DEC_LATENCY

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- PADDR  in  AMBA_ADDR_WIDTH  APB address
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PWDATA  in  AMBA_WORD  APB write data
- PRDATA  out  AMBA_WORD  APB read data
- dp_start  out  1  one-cycle launch pulse to datapath
- dp_op  out  2  0 encode, 1 decode, 2 full channel
- dp_data_in  out  MAX_CODEWORD_WIDTH  DATA_IN register
- dp_work_mod  out  AMBA_WORD  CODEWORD_WIDTH register
- dp_noise  out  MAX_CODEWORD_WIDTH  NOISE register
- dp_data_out  in  MAX_CODEWORD_WIDTH  datapath result
- dp_num_of_errors  in  2  datapath error count (decode/full only)
- data_out  out  MAX_CODEWORD_WIDTH  captured result
- num_of_errors  out  2  captured error count
- operation_done  out  1  one-cycle completion pulse

## Operation
- Register map, by PADDR[4:2]:
  - 0: CTRL, bits [1:0]
  - 1: DATA_IN
  - 2: CODEWORD_WIDTH, bits [1:0]
  - 3: NOISE
  - 4: STATUS, read-only: bit0 busy, bit1 sticky illegal-command, bits [5:4] num_of_errors
  - Other addresses: reads return 0; writes are ignored.
- A write commits on the clock edge where PSEL & PENABLE & PWRITE are all high. Unused register bits read 0.
- PRDATA is combinational when PSEL & PENABLE & !PWRITE and is 0 otherwise. Reads are legal in any state and have no side effects.
- States:
  - IDLE: a CTRL write with op in {0,1,2} and CODEWORD_WIDTH in {0,1,2} moves to LAUNCH. A CTRL write with op==3 or CODEWORD_WIDTH==3 stays in IDLE and sets the sticky illegal bit. A CTRL write with a legal command clears the sticky bit.
  - LAUNCH: dp_start=1 for exactly this cycle and the latency counter loads L (L=ENC_LATENCY, DEC_LATENCY, or their sum, selected by op). Moves to WAIT.
  - WAIT: the counter decrements each cycle. At count==1 the controller captures dp_data_out into data_out and dp_num_of_errors into num_of_errors (num_of_errors forced to 0 for encode), then moves to DONE.
  - DONE: operation_done=1 for one cycle, then IDLE.
- busy=1 in LAUNCH, WAIT and DONE. While busy, all APB writes (any register) are dropped, so operands stay stable for the whole operation.
- dp_op, dp_data_in, dp_work_mod and dp_noise are continuous copies of the registers.

## Timing
- Reset (rst low, asynchronous): all registers, data_out, num_of_errors, operation_done, dp_start and PRDATA go to 0. State goes to IDLE and the sticky bit clears.
  - Reset mid-operation aborts the operation: no operation_done pulse and no capture.
- Latency: write edge E0, then dp_start high during cycle E0+1, then capture at edge E0+1+L, then operation_done high for the cycle after that edge.
  - Encode with defaults: operation_done is high in the 3rd cycle after E0.
- A CTRL write in the same cycle that DONE returns to IDLE is dropped, because busy is still 1. A new command is accepted from the first IDLE cycle onward.
- data_out and num_of_errors hold their values until the next capture or reset.

## Test plan
- Reset: hold rst low, then release → every output reads 0, STATUS=0x0, PRDATA=0 on reads of all addresses.
- Encode with a stub datapath returning dp_data_in^0xA5A5A5A5 after 1 cycle:
  - Stimulus: write CODEWORD_WIDTH=0, DATA_IN=0x5, CTRL=0.
  - Required: dp_start pulses once, data_out=0xA5A5A5A0, operation_done high for 1 cycle exactly 3 cycles after the CTRL write edge, num_of_errors=0.
- Full channel with the stub delaying 4 cycles and returning errors=2:
  - Stimulus: CODEWORD_WIDTH=2, NOISE=0x3, CTRL=2.
  - Required: operation_done 6 cycles after the write edge, num_of_errors=2, STATUS[5:4]=2.
- Busy protection: while WAIT, write DATA_IN=0xFFFF and CTRL=1 → both dropped, dp_data_in unchanged, exactly one operation_done.
- Illegal command: CTRL=3 → no dp_start, STATUS bit1=1. A following legal CTRL write clears it and runs normally.
- Reset mid-WAIT: assert rst during a decode → no operation_done, data_out=0. The next command after reset completes normally.
